// File: rtl/famiclone_detect_pkg.sv
// rtl/famiclone_detect_pkg.sv - mode codes and FSM states for the console-type detector
package famiclone_detect_pkg;

  localparam logic [1:0] MODE_PENDING   = 2'b00;
  localparam logic [1:0] MODE_CLASSIC   = 2'b01;
  localparam logic [1:0] MODE_FAMICLONE = 2'b10;
  localparam logic [1:0] MODE_NO_PPU    = 2'b11;

  typedef enum logic [1:0] {
    GROUND = 2'b00,
    SETTLE = 2'b01,
    SAMPLE = 2'b10,
    DONE   = 2'b11
  } state_t;

endpackage

// File: rtl/famiclone_detect_ppu_rd_sync.sv
// rtl/famiclone_detect_ppu_rd_sync.sv - coherent PPU pin synchroniser with /RD falling-edge strobe
module ppu_rd_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic m2,
  input  logic rst_n,
  input  logic rd_in,
  input  logic a13_in,
  input  logic not_a13_in,
  output logic sample_stb,
  output logic a13_s,
  output logic not_a13_s
);

  // Bit 2 = /RD, bit 1 = A13, bit 0 = /A13; the triplet moves as one word.
  logic [SYNC_STAGES-1:0][2:0] chain;
  logic                        rd_prev;

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      chain   <= '0;
      rd_prev <= 1'b0;
    end else begin
      chain   <= {chain[SYNC_STAGES-2:0], {rd_in, a13_in, not_a13_in}};
      rd_prev <= chain[SYNC_STAGES-1][2];
    end
  end

  assign sample_stb = rd_prev & ~chain[SYNC_STAGES-1][2];
  assign a13_s      = chain[SYNC_STAGES-1][1];
  assign not_a13_s  = chain[SYNC_STAGES-1][0];

endmodule

// File: rtl/famiclone_detect.sv
// rtl/famiclone_detect.sv - power-on classic / famiclone / no-PPU host detector in the M2 domain
module famiclone_detect
  import famiclone_detect_pkg::*;
#(
  parameter int INIT_CYCLES     = 15,
  parameter int SAMPLES_LO      = 3,
  parameter int SAMPLES_HI      = 3,
  parameter int MISMATCH_THRESH = 1,
  parameter int TIMEOUT_CYCLES  = 65535,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       m2,
  input  logic       rst_n,
  input  logic       ppu_rd_in,
  input  logic       ppu_a13_in,
  input  logic       ppu_not_a13_in,
  input  logic       rearm,
  output logic       ground_en,
  output logic       detect_done,
  output logic [1:0] mode,
  output logic       new_dendy
);

  localparam int HW  = $clog2(INIT_CYCLES + 1);
  localparam int SW  = $clog2(SYNC_STAGES + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW  = $clog2(SAMPLES_LO + 1);
  localparam int HIW = $clog2(SAMPLES_HI + 1);
  localparam int MW  = $clog2(MISMATCH_THRESH + 1);

  localparam logic [HW-1:0]  HOLD_LAST   = HW'(INIT_CYCLES - 1);
  localparam logic [SW-1:0]  SETTLE_LAST = SW'(SYNC_STAGES - 1);
  localparam logic [TW-1:0]  TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0]  LO_TGT      = LW'(SAMPLES_LO);
  localparam logic [HIW-1:0] HI_TGT      = HIW'(SAMPLES_HI);
  localparam logic [MW-1:0]  MIS_TGT     = MW'(MISMATCH_THRESH);

  state_t state, state_nx;

  logic [HW-1:0]  hold_cnt;
  logic [SW-1:0]  settle_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic [LW-1:0]  lo_cnt, lo_nx;
  logic [HIW-1:0] hi_cnt, hi_nx;
  logic [MW-1:0]  mis_cnt, mis_nx;

  logic sample_stb, a13_s, not_a13_s;
  logic hold_end, settle_end, tmo_end, is_fam, is_classic;
  logic       ground_d, done_d, dendy_d;
  logic [1:0] mode_d;

  ppu_rd_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .m2         (m2),
    .rst_n      (rst_n),
    .rd_in      (ppu_rd_in),
    .a13_in     (ppu_a13_in),
    .not_a13_in (ppu_not_a13_in),
    .sample_stb (sample_stb),
    .a13_s      (a13_s),
    .not_a13_s  (not_a13_s)
  );

  assign hold_end   = (hold_cnt == HOLD_LAST);
  assign settle_end = (settle_cnt == SETTLE_LAST);
  assign tmo_end    = (tmo_cnt == TMO_LAST);

  // Decisions look at the counts this edge will register, so the deciding sample wins over timeout.
  always_comb begin
    lo_nx  = lo_cnt;
    hi_nx  = hi_cnt;
    mis_nx = mis_cnt;
    if (sample_stb) begin
      if (!a13_s && lo_cnt != LO_TGT)      lo_nx  = lo_cnt + LW'(1);
      if (a13_s && hi_cnt != HI_TGT)       hi_nx  = hi_cnt + HIW'(1);
      if (not_a13_s == a13_s && mis_cnt != MIS_TGT) mis_nx = mis_cnt + MW'(1);
    end
  end

  assign is_fam     = (mis_nx == MIS_TGT);
  assign is_classic = (lo_nx == LO_TGT) && (hi_nx == HI_TGT);

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) state <= GROUND;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (rearm) state_nx = GROUND;
    else begin
      case (state)
        GROUND: if (hold_end)   state_nx = SETTLE;
        SETTLE: if (settle_end) state_nx = SAMPLE;
        SAMPLE: if (is_fam || is_classic || tmo_end) state_nx = DONE;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n || rearm) begin
      hold_cnt   <= '0;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      lo_cnt     <= '0;
      hi_cnt     <= '0;
      mis_cnt    <= '0;
    end else begin
      case (state)
        GROUND: if (!hold_end)   hold_cnt   <= hold_cnt + HW'(1);
        SETTLE: if (!settle_end) settle_cnt <= settle_cnt + SW'(1);
        SAMPLE: begin
          lo_cnt  <= lo_nx;
          hi_cnt  <= hi_nx;
          mis_cnt <= mis_nx;
          if (!tmo_end) tmo_cnt <= tmo_cnt + TW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ground_d = (state_nx == GROUND);
    done_d   = (state_nx == DONE);
    mode_d   = mode;
    if (rearm)                 mode_d = MODE_PENDING;
    else if (state == SAMPLE) begin
      if (is_fam)              mode_d = MODE_FAMICLONE;
      else if (is_classic)     mode_d = MODE_CLASSIC;
      else if (tmo_end)        mode_d = MODE_NO_PPU;
    end
    dendy_d = (mode_d == MODE_FAMICLONE);
  end

  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      ground_en   <= 1'b1;
      detect_done <= 1'b0;
      mode        <= MODE_PENDING;
      new_dendy   <= 1'b0;
    end else begin
      ground_en   <= ground_d;
      detect_done <= done_d;
      mode        <= mode_d;
      new_dendy   <= dendy_d;
    end
  end

endmodule

// File: tb/tb_famiclone_detect.sv
// tb/tb_famiclone_detect.sv - scoreboard bench for famiclone_detect with directed PPU strobe sequences
module tb_famiclone_detect;

  logic       m2 = 1'b0;
  logic       rst_n, rd, a13, na13, rearm;
  logic       ground_en, detect_done, new_dendy;
  logic [1:0] mode;

  typedef struct {
    logic [1:0] mode;
    logic       dendy;
    int         edge_at;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  logic prev_done = 1'b0;
  int   base, r0;

  famiclone_detect #(.TIMEOUT_CYCLES(100)) dut (
    .m2             (m2),
    .rst_n          (rst_n),
    .ppu_rd_in      (rd),
    .ppu_a13_in     (a13),
    .ppu_not_a13_in (na13),
    .rearm          (rearm),
    .ground_en      (ground_en),
    .detect_done    (detect_done),
    .mode           (mode),
    .new_dendy      (new_dendy)
  );

  always #5 m2 = ~m2;
  always @(posedge m2) edge_n++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  // Monitor: every rising detect_done is matched against the oldest expected result.
  always @(negedge m2) begin
    if (detect_done && !prev_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got mode %0d at edge %0d expected no result", mode, edge_n);
      end else begin
        e = exp_q.pop_front();
        check("done_mode", 32'(mode), 32'(e.mode));
        check("done_dendy", 32'(new_dendy), 32'(e.dendy));
        check("done_edge", 32'(edge_n), 32'(e.edge_at));
      end
    end
    prev_done = detect_done;
  end

  task automatic push(input logic [1:0] m, input logic d, input int at);
    exp_t x;
    x.mode = m; x.dendy = d; x.edge_at = at;
    exp_q.push_back(x);
  endtask

  // Called just after a negedge; /RD low for one cycle, then high for one.
  task automatic strobe(input logic a, input logic na);
    rd = 1'b0; a13 = a; na13 = na;
    @(negedge m2);
    rd = 1'b1;
    @(negedge m2);
    a13 = 1'b0; na13 = 1'b1;
  endtask

  task automatic wait_until(input int target);
    while (edge_n < target) @(negedge m2);
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      @(negedge m2);
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_rearm(output int b);
    rearm = 1'b1;
    b = edge_n + 1;
    @(negedge m2);
    rearm = 1'b0;
    check("rearm_ground", 32'(ground_en), 32'd1);
    check("rearm_done", 32'(detect_done), 32'd0);
    check("rearm_mode", 32'(mode), 32'd0);
    check("rearm_dendy", 32'(new_dendy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rd = 1'b1; a13 = 1'b0; na13 = 1'b1; rearm = 1'b0;
    repeat (3) @(negedge m2);
    check("rst_ground", 32'(ground_en), 32'd1);
    check("rst_done", 32'(detect_done), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_dendy", 32'(new_dendy), 32'd0);

    // Hold-off: high after edges 1..14, low from edge 15.
    rst_n = 1'b1;
    r0 = edge_n;
    for (int k = 1; k <= 16; k++) begin
      @(negedge m2);
      check("hold_ground", 32'(ground_en), (k < 15) ? 32'd1 : 32'd0);
      check("hold_mode", 32'(mode), 32'd0);
    end

    // Classic: interleaved lo/hi reads, result 3 edges after the 6th fall.
    wait_until(r0 + 16);
    strobe(1'b0, 1'b1); strobe(1'b1, 1'b0); strobe(1'b0, 1'b1);
    strobe(1'b1, 1'b0); strobe(1'b0, 1'b1);
    push(2'b01, 1'b0, edge_n + 3);
    strobe(1'b1, 1'b0);
    wait_drain(20);
    check("classic_ground", 32'(ground_en), 32'd0);

    // Famiclone on the second read, before lo/hi targets.
    do_rearm(base);
    wait_until(base + 16);
    strobe(1'b0, 1'b1);
    push(2'b10, 1'b1, edge_n + 3);
    strobe(1'b1, 1'b1);
    wait_drain(20);

    // No reads: NO_PPU 100 edges after SAMPLE is entered (base+17).
    do_rearm(base);
    push(2'b11, 1'b0, base + 117);
    wait_drain(200);

    // Sixth sample counts on the same edge as the final timeout count.
    do_rearm(base);
    wait_until(base + 16);
    strobe(1'b0, 1'b1); strobe(1'b0, 1'b1); strobe(1'b0, 1'b1);
    strobe(1'b1, 1'b0); strobe(1'b1, 1'b0);
    wait_until(base + 114);
    push(2'b01, 1'b0, base + 117);
    strobe(1'b1, 1'b0);
    wait_drain(20);
    repeat (3) @(negedge m2);
    check("tie_mode_hold", 32'(mode), 32'd1);

    // Async reset mid-SAMPLE, then counters must start from zero again.
    do_rearm(base);
    wait_until(base + 16);
    strobe(1'b0, 1'b1); strobe(1'b0, 1'b1);
    repeat (4) @(negedge m2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ground", 32'(ground_en), 32'd1);
    check("arst_mode", 32'(mode), 32'd0);
    check("arst_done", 32'(detect_done), 32'd0);
    @(negedge m2);
    rst_n = 1'b1;
    r0 = edge_n;
    wait_until(r0 + 16);
    strobe(1'b1, 1'b0); strobe(1'b1, 1'b0); strobe(1'b1, 1'b0);
    strobe(1'b0, 1'b1); strobe(1'b0, 1'b1);
    push(2'b01, 1'b0, edge_n + 3);
    strobe(1'b0, 1'b1);
    wait_drain(20);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
